// File: rtl/kyber_pkg.sv
// Shared Kyber datapath package.
// Provides the 16-bit signed coefficient type, the field modulus, the fqmul
// result latency, the multiplier scheduler state encoding, and a helper that
// sizes index fields.
package kyber_pkg;

  typedef logic signed [15:0] coeff_t;

  localparam int KYBER_Q   = 3329;
  // fqmul: 1 multiply cycle followed by 3 Montgomery reduction cycles.
  localparam int FQMUL_LAT = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } fqsched_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fqmul_sched_rr_pick.sv
// rr_pick: purely combinational round-robin priority picker.
// Searches req starting at position ptr and wrapping modulo NREQ. It returns
// the first requester it finds as a one-hot grant and as a binary index.
// Ports:
//   req  [NREQ]  request vector
//   ptr  [PW]    highest-priority position for this search
//   gnt  [NREQ]  one-hot grant, all zero when nothing is requested
//   idx  [PW]    index of the granted requester (0 when none)
//   any          at least one request is present
module rr_pick
  import kyber_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int            j;
  logic [PW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/fqmul_sched.sv
// fqmul_sched: round-robin scheduler that shares one non-pipelined fqmul
// Montgomery multiplier among NREQ requesters.
// One operand pair is accepted in IDLE. The multiplier is started for one
// cycle, and its result is sampled MUL_LAT cycles after the start cycle. The
// product is then returned to the granted requester over a valid/ready
// response. The round-robin pointer advances only when a response completes.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  per-requester operand handshake (ready is one-hot)
//   req_a, req_b         per-requester signed operands
//   rsp_valid/rsp_ready  per-requester result handshake (valid is one-hot)
//   rsp_r                result shared by all requesters
//   busy                 high whenever not in IDLE
//   mul_start            one-cycle start pulse to fqmul
//   mul_a, mul_b         registered operands to fqmul
//   mul_r                fqmul result
module fqmul_sched
  import kyber_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = FQMUL_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  coeff_t          req_a [NREQ],
  input  coeff_t          req_b [NREQ],
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output coeff_t          rsp_r,
  output logic            busy,
  output logic            mul_start,
  output coeff_t          mul_a,
  output coeff_t          mul_b,
  input  coeff_t          mul_r
);

  localparam int PW = idx_w(NREQ);
  localparam int CW = idx_w(MUL_LAT);

  fqsched_state_t  state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Outputs are decoded from registered state. The exception is req_ready,
  // which must answer the current req_valid combinationally in IDLE. It is
  // masked by rst so that no handshake can complete while reset is applied.
  assign req_ready = (state == S_IDLE && !rst) ? pick_gnt : '0;
  assign rsp_valid = (state == S_RESP) ? (NREQ'(1) << gidx) : '0;
  assign mul_start = (state == S_START);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      gidx  <= '0;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      rsp_r <= '0;
    end else begin
      case (state)
        // Accept: capture the winner's operands and remember who it was.
        S_IDLE: begin
          if (pick_any) begin
            mul_a <= req_a[pick_idx];
            mul_b <= req_b[pick_idx];
            gidx  <= pick_idx;
            state <= S_START;
          end
        end
        // Start pulse to fqmul.
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        // Latency count. The last count is the cycle in which mul_r is valid.
        S_WAIT: begin
          if (cnt == CW'(MUL_LAT - 1)) begin
            rsp_r <= mul_r;
            state <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // Response: only the granted requester's ready can complete it.
        S_RESP: begin
          if (rsp_ready[gidx]) begin
            ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fqmul_sched.sv
// Testbench for fqmul_sched. An fqmul behavioural model drives mul_r with
// the Montgomery product only in the cycle MUL_LAT after mul_start, and with
// random values in every other cycle. A round-robin/latency reference model
// predicts grants, timing and results.
module tb_fqmul_sched;
  import kyber_pkg::*;

  localparam int N   = 4;
  localparam int LAT = FQMUL_LAT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  coeff_t       opa [N];
  coeff_t       opb [N];
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready = '0;
  coeff_t       rsp_r;
  logic         busy;
  logic         mul_start;
  coeff_t       mul_a, mul_b;
  coeff_t       mul_r = '0;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int mptr = 0;

  fqmul_sched #(.NREQ(N), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(opa), .req_b(opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .busy(busy), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Montgomery product a*b*2^-16 mod q, as the Kyber reference computes it.
  function automatic coeff_t fqmul_ref(input coeff_t a, input coeff_t b);
    int p;
    logic signed [15:0] t;
    int r;
    p = int'(a) * int'(b);
    t = 16'(p * -3327);
    r = (p - int'(t) * KYBER_Q) >>> 16;
    return coeff_t'(r);
  endfunction

  // fqmul model: the result is valid only in cycle start+LAT.
  coeff_t m_res = '0;
  int     m_dly = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_res <= fqmul_ref(mul_a, mul_b);
      m_dly <= LAT - 1;
      mul_r <= coeff_t'($urandom);
    end else if (m_dly == 1) begin
      m_dly <= 0;
      mul_r <= m_res;
    end else if (m_dly > 1) begin
      m_dly <= m_dly - 1;
      mul_r <= coeff_t'($urandom);
    end else begin
      mul_r <= coeff_t'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic coeff_t rnd();
    return coeff_t'(int'($urandom_range(6656, 0)) - 3328);
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    return N'(1) << g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: present reqs, check the grant, the start pulse,
  // the response latency and value, and optional response back-pressure.
  task automatic do_op(input logic [N-1:0] reqs, input int stall, input bit wrong,
                       input bit keep, output int acc);
    int g, wd;
    coeff_t ea, eb, er;
    logic [N-1:0] gm;
    req_valid = reqs;
    rsp_ready = '0;
    g  = pick(reqs, mptr);
    gm = oh(g);
    ea = opa[g];
    eb = opb[g];
    er = fqmul_ref(ea, eb);
    wd = 0;
    to_sample();
    while (req_ready == '0 && wd < 40) begin
      to_drive();
      to_sample();
      wd++;
    end
    chk("accept_seen", 32'(req_ready != '0), 1);
    chk("req_ready_grant", 32'(req_ready), 32'(gm));
    chk("busy_idle", 32'(busy), 0);
    chk("rsp_valid_idle", 32'(rsp_valid), 0);
    acc = cyc;
    to_drive();
    if (!keep) req_valid[g] = 1'b0;
    opa[g] = rnd();
    opb[g] = rnd();
    to_sample();
    chk("mul_start_pulse", 32'(mul_start), 1);
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    chk("busy_start", 32'(busy), 1);
    chk("req_ready_busy", 32'(req_ready), 0);
    for (int k = 2; k <= LAT + 1; k++) begin
      to_drive();
      to_sample();
      chk("mul_start_low", 32'(mul_start), 0);
      chk("rsp_valid_wait", 32'(rsp_valid), 0);
      chk("mul_a_stable", 32'(mul_a), 32'(ea));
    end
    to_drive();
    if (stall == 0) rsp_ready = gm;
    else if (wrong) rsp_ready = ~gm;
    to_sample();
    chk("rsp_latency", 32'(cyc - acc), LAT + 2);
    chk("rsp_valid", 32'(rsp_valid), 32'(gm));
    chk("rsp_r", 32'(rsp_r), 32'(er));
    chk("req_ready_resp", 32'(req_ready), 0);
    for (int s = 1; s <= stall; s++) begin
      to_drive();
      if (s == stall) rsp_ready = gm;
      to_sample();
      chk("rsp_valid_hold", 32'(rsp_valid), 32'(gm));
      chk("rsp_r_hold", 32'(rsp_r), 32'(er));
      chk("req_ready_stall", 32'(req_ready), 0);
      chk("busy_stall", 32'(busy), 1);
    end
    to_drive();
    rsp_ready = '0;
    mptr = (g + 1) % N;
  endtask

  initial begin
    int acc, prev;
    for (int i = 0; i < N; i++) begin
      opa[i] = rnd();
      opb[i] = rnd();
    end

    // Reset: req_ready must stay low even with every request pending.
    rst = 1'b1;
    req_valid = '1;
    repeat (3) to_drive();
    to_sample();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_start", 32'(mul_start), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_rsp_r", 32'(rsp_r), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    to_drive();
    rst = 1'b0;
    req_valid = '0;

    // All ports requesting continuously: grants 0,1,2,3,0, seven cycles apart.
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(4'b1111, 0, 1'b0, 1'b1, acc);
      if (i > 0) chk("issue_interval", 32'(acc - prev), LAT + 3);
      prev = acc;
    end

    // Single request on port 0 with a=3, b=5.
    opa[0] = 16'sd3;
    opb[0] = 16'sd5;
    do_op(4'b0001, 0, 1'b0, 1'b0, acc);
    to_sample();
    chk("busy_after_single", 32'(busy), 0);
    chk("rsp_valid_after_single", 32'(rsp_valid), 0);
    to_drive();

    // Port 1 back-pressured for 5 cycles.
    do_op(4'b0010, 5, 1'b0, 1'b0, acc);
    to_sample();
    chk("rsp_valid_after_stall", 32'(rsp_valid), 0);
    chk("busy_after_stall", 32'(busy), 0);
    to_drive();

    // Move the pointer to 3, then ports 3 and 0 alternate across the wrap.
    do_op(4'b0100, 0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) do_op(4'b1001, 0, 1'b0, 1'b1, acc);
    req_valid = '0;

    // Port 2 pending while other ports (including 0) assert rsp_ready.
    do_op(4'b0100, 3, 1'b1, 1'b0, acc);

    // Reset in the WAIT cycle with counter=2; the stale product is dropped.
    req_valid = 4'b0010;
    to_sample();
    chk("mid_accept", 32'(req_ready), 32'(oh(pick(4'b0010, mptr))));
    to_drive();
    req_valid = '0;
    to_sample();
    chk("mid_mul_start", 32'(mul_start), 1);
    to_drive();
    to_drive();
    to_drive();
    rst = 1'b1;
    to_sample();
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    to_drive();
    rst = 1'b0;
    to_sample();
    chk("mid_busy", 32'(busy), 0);
    chk("mid_mul_start_low", 32'(mul_start), 0);
    chk("mid_mul_a", 32'(mul_a), 0);
    chk("mid_mul_b", 32'(mul_b), 0);
    chk("mid_rsp_r", 32'(rsp_r), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    mptr = 0;
    for (int i = 0; i < 4; i++) begin
      to_drive();
      to_sample();
      chk("stale_rsp_valid", 32'(rsp_valid), 0);
      chk("stale_rsp_r", 32'(rsp_r), 0);
    end
    to_drive();
    do_op(4'b0100, 0, 1'b0, 1'b0, acc);

    // A few random request mixes with random back-pressure.
    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(15, 1));
      do_op(r, int'($urandom_range(2, 0)), 1'b1, 1'b0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
